// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Sequences a 4*NIBBLES-bit add through one shared 4-bit adder,
//            one nibble per clock, LSB first, with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic            w_run;

    // Nibble select driven only from registers so the external adder has a full cycle to settle.
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    assign w_run   = (r_state == S_RUN);
    assign add_a   = w_run ? w_a_nib : 4'h0;
    assign add_b   = w_run ? w_b_nib : 4'h0;
    assign add_cin = w_run ? r_carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= op_cin;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            sum[4*i +: 4] <= add_s;
                        end
                    end
                    r_carry <= add_cout;
                    if (r_idx == C_LAST_IDX) begin
                        cout    <= add_cout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // start here is deliberately dropped; the requester re-asserts in IDLE.
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add_ctrl
// Brief    : Directed self-checking bench for nibble_serial_add_ctrl
//            (NIBBLES=4 and NIBBLES=1 instances, behavioural 4-bit adders).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    int          total;
    int          bad;

    // NIBBLES = 4 instance
    logic        start4, cin4, busy4, done4, cout4;
    logic [15:0] a4, b4, sum4;
    logic [3:0]  add_a4, add_b4, add_s4;
    logic        add_cin4, add_cout4;

    // NIBBLES = 1 instance
    logic        start1, cin1, busy1, done1, cout1;
    logic [3:0]  a1, b1, sum1;
    logic [3:0]  add_a1, add_b1, add_s1;
    logic        add_cin1, add_cout1;

    assign {add_cout4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};
    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};

    nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4), .op_cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_s(add_s4), .add_cout(add_cout4)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .op_cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns just after the accepting edge E; the next negedge lies in RUN cycle 1.
    task automatic apply4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = 16'h0; b4 = 16'h0; cin4 = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL reset_flags4 busy=%b done=%b want 0 0", busy4, done4); end
        total++; if (sum4 !== 16'h0 || cout4 !== 1'b0) begin bad++; $display("FAIL reset_result4 sum=%h cout=%b want 0000 0", sum4, cout4); end
        total++; if (add_a4 !== 4'h0 || add_b4 !== 4'h0 || add_cin4 !== 1'b0) begin bad++; $display("FAIL reset_adder4 a=%h b=%h cin=%b want 0 0 0", add_a4, add_b4, add_cin4); end
        total++; if (sum1 !== 4'h0 || cout1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_dut1 sum=%h cout=%b busy=%b done=%b want 0", sum1, cout1, busy1, done1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (add_a4 !== 4'h0 || busy4 !== 1'b0) begin bad++; $display("FAIL idle_adder4 a=%h busy=%b want 0 0", add_a4, busy4); end
    endtask

    task automatic test_basic;
        apply4(16'h1234, 16'h4321, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin bad++; $display("FAIL basic_run%0d busy=%b done=%b want 1 0", k, busy4, done4); end
        end
        @(negedge clk);
        total++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin bad++; $display("FAIL basic_done done=%b busy=%b want 1 0", done4, busy4); end
        total++; if (sum4 !== 16'h5555 || cout4 !== 1'b0) begin bad++; $display("FAIL basic_sum sum=%h cout=%b want 5555 0", sum4, cout4); end
        @(negedge clk);
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL basic_pulse done=%b want 0", done4); end
        repeat (3) @(negedge clk);
        total++; if (sum4 !== 16'h5555 || cout4 !== 1'b0) begin bad++; $display("FAIL basic_hold sum=%h cout=%b want 5555 0", sum4, cout4); end
    endtask

    task automatic test_carry_ripple;
        logic [3:0] cins;
        cins = 4'h0;
        apply4(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cins[k] = add_cin4;
            if (k == 0) begin
                total++; if (add_a4 !== 4'hF || add_b4 !== 4'h1) begin bad++; $display("FAIL ripple_slice0 a=%h b=%h want f 1", add_a4, add_b4); end
            end
        end
        total++; if (cins !== 4'b1110) begin bad++; $display("FAIL ripple_cin_seq got=%b want 1110 (lsb=cycle0)", cins); end
        @(negedge clk);
        total++; if (done4 !== 1'b1 || sum4 !== 16'h0000 || cout4 !== 1'b1) begin bad++; $display("FAIL ripple_result done=%b sum=%h cout=%b want 1 0000 1", done4, sum4, cout4); end
    endtask

    task automatic test_cin_wrap;
        apply4(16'hFFFF, 16'h0000, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (done4 !== 1'b1 || sum4 !== 16'h0000 || cout4 !== 1'b1) begin bad++; $display("FAIL cinwrap_result done=%b sum=%h cout=%b want 1 0000 1", done4, sum4, cout4); end
    endtask

    task automatic test_ignore_start;
        int dones;
        apply4(16'h00FF, 16'h0001, 1'b0);
        repeat (2) @(negedge clk);
        start4 = 1'b1; a4 = 16'hAAAA;
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (done4 !== 1'b1 || sum4 !== 16'h0100 || cout4 !== 1'b0) begin bad++; $display("FAIL ignore_result done=%b sum=%h cout=%b want 1 0100 0", done4, sum4, cout4); end
        start4 = 1'b1; a4 = 16'hAAAA;
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = 16'h0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) dones++;
        end
        total++; if (dones !== 0 || sum4 !== 16'h0100) begin bad++; $display("FAIL ignore_extra active_cycles=%0d sum=%h want 0 0100", dones, sum4); end
        apply4(16'hAAAA, 16'h5555, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (done4 !== 1'b1 || sum4 !== 16'h0000 || cout4 !== 1'b1) begin bad++; $display("FAIL ignore_next done=%b sum=%h cout=%b want 1 0000 1", done4, sum4, cout4); end
    endtask

    task automatic test_async_reset;
        int dones;
        apply4(16'h8888, 16'h8888, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 16'h0 || cout4 !== 1'b0) begin bad++; $display("FAIL areset_outputs busy=%b done=%b sum=%h cout=%b want 0 0 0000 0", busy4, done4, sum4, cout4); end
        total++; if (add_a4 !== 4'h0 || add_b4 !== 4'h0 || add_cin4 !== 1'b0) begin bad++; $display("FAIL areset_adder a=%h b=%h cin=%b want 0 0 0", add_a4, add_b4, add_cin4); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL areset_no_done active_cycles=%0d want 0", dones); end
        apply4(16'h8888, 16'h8888, 1'b0);
        repeat (5) @(negedge clk);
        total++; if (done4 !== 1'b1 || sum4 !== 16'h1110 || cout4 !== 1'b1) begin bad++; $display("FAIL areset_rerun done=%b sum=%h cout=%b want 1 1110 1", done4, sum4, cout4); end
    endtask

    task automatic test_nibbles1;
        @(negedge clk);
        start1 = 1'b1; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
        @(negedge clk);
        total++; if (busy1 !== 1'b1 || done1 !== 1'b0 || add_a1 !== 4'hF || add_cin1 !== 1'b1) begin bad++; $display("FAIL n1_run busy=%b done=%b add_a=%h add_cin=%b want 1 0 f 1", busy1, done1, add_a1, add_cin1); end
        @(negedge clk);
        total++; if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 4'hF || cout1 !== 1'b1) begin bad++; $display("FAIL n1_done done=%b busy=%b sum=%h cout=%b want 1 0 f 1", done1, busy1, sum1, cout1); end
        @(negedge clk);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL n1_pulse done=%b want 0", done1); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = 16'h0; b4 = 16'h0; cin4 = 1'b0;
        start1 = 1'b0; a1 = 4'h0;  b1 = 4'h0;  cin1 = 1'b0;
        test_reset;
        test_basic;
        test_async_reset;
        test_carry_ripple;
        test_cin_wrap;
        test_ignore_start;
        test_nibbles1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes a wide add (4*NIBBLES bits) on one shared 4-bit ripple adder, one nibble per clock, LSB first.
- Latches both operands, drives nibble slices and the running carry into the external 4-bit adder, collects the sum nibbles, and reports the result with a one-cycle done pulse.
- Sits between a requester issuing wide adds and the existing 4-bit adder datapath, which stays purely combinational.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset; one clock; asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- op_a  input  W  operand A; sampled on the accepting edge
- op_b  input  W  operand B; sampled on the accepting edge
- op_cin  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  W  result register
- cout  output  1  final carry-out register
- add_a  output  4  to shared adder operand A
- add_b  output  4  to shared adder operand B
- add_cin  output  1  to shared adder carry-in
- add_s  input  4  from shared adder sum
- add_cout  input  1  from shared adder carry-out

Behaviour:
- States: IDLE, RUN, DONE.
- Internal registers: a_reg, b_reg (W), carry (1), idx (ceil log2 NIBBLES, min 1).
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE; busy, done, cout, carry, idx = 0; sum, a_reg, b_reg = 0.
  - Aborted operations produce no done pulse.
- IDLE:
  - add_a, add_b, add_cin driven 0.
  - On start=1 at a rising edge: a_reg <= op_a, b_reg <= op_b, carry <= op_cin, idx <= 0, state <= RUN.
  - sum and cout keep their previous values until the first RUN edge.
- RUN:
  - busy=1.
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[same slice], add_cin = carry. These are combinational from registers, so the adder settles within the cycle.
  - Each edge: sum[4*idx+3:4*idx] <= add_s, carry <= add_cout.
  - If idx == NIBBLES-1: cout <= add_cout, state <= DONE. Otherwise idx <= idx+1.
  - Nibbles of sum above idx hold stale values during RUN and are not valid until done.
- DONE:
  - done=1 for exactly one cycle, busy=0, adder inputs driven 0.
  - Next edge: state <= IDLE.
  - start in DONE is ignored; the requester must re-assert in IDLE.
- Latency:
  - start accepted at edge E.
  - RUN occupies the NIBBLES cycles following E.
  - done is high in cycle E+NIBBLES+1.
  - Throughput is one add per NIBBLES+2 cycles.
- start, op_a, op_b, op_cin while busy or done: ignored, with no effect on the operation in flight.
- sum and cout hold their values after DONE until the next accepted start begins overwriting them.
- Arithmetic: {cout,sum} == op_a + op_b + op_cin modulo 2^(W+1).
  - Carry ripples across nibbles through the carry register.
  - All-ones plus carry-in wraps sum to 0 with cout=1.
- NIBBLES=1: RUN lasts one cycle; idx stays 0.

Test Plan:
- Bench instantiates the block with a behavioural 4-bit adder on the add_* ports.
1. NIBBLES=4: op_a=16'h1234, op_b=16'h4321, op_cin=0, start pulse -> busy high for 4 cycles; done in cycle 5 after acceptance; sum=16'h5555, cout=0.
2. op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> sum=16'h0000, cout=1. Check add_cin = 0,1,1,1 across the four RUN cycles.
3. op_a=16'hFFFF, op_b=16'h0000, op_cin=1 -> sum=16'h0000, cout=1.
4. Start 16'h00FF+16'h0001, then pulse start with op_a=16'hAAAA mid-RUN and again in DONE -> single done, sum=16'h0100. Block returns to IDLE and then accepts 16'hAAAA+16'h5555, cin=1 -> sum=16'h0000, cout=1.
5. Assert rst_n=0 asynchronously in the 2nd RUN cycle of 16'h8888+16'h8888 -> outputs zero immediately. No done pulse follows. A fresh start after release yields the correct result 16'h1110, cout=1.
6. NIBBLES=1: op_a=4'hF, op_b=4'hF, op_cin=1 -> done 2 cycles after acceptance, sum=4'hF, cout=1.
